alu_exec_unit: RTL and testbench

- Execution-side consumer of the 4-bit alu_control code produced by the ALU control decoder.
- Accepts one operation (code plus two operands) over a valid/ready handshake and computes the result.
- Holds the result under a valid/ready output handshake.
- Single-cycle ops take 1 cycle; the added MUL op runs iteratively over WIDTH cycles, for the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_exec_unit_mult.sv | 77 +++++++
 rtl/alu_exec_unit.sv | 131 +++++++++++++
 tb/tb_alu_exec_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execution-unit state encoding.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;
   localparam logic [3:0] ALU_INV = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_mult.sv
// Serial shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module alu_mult_serial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand_in,
   input  logic [WIDTH-1:0] mplier_in,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;
   logic [WIDTH-1:0] acc_sum;

   // product is the accumulator including this cycle's partial product,
   // so the top can register it on the same edge that done is seen.
   always_comb begin
      acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
      done    = run_q && (cnt_q == LAST);
      product = acc_sum;
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (clear) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         mcand_d  = mcand_in;
         mplier_d = mplier_in;
         acc_d    = '0;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (done) begin
            run_d = 1'b0;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith ops plus a serial MUL, with
// valid/ready handshakes on both the operation input and the held result.
//
// state | meaning
// IDLE  | ready to accept an operation
// MUL   | serial multiplier iterating
// DONE  | result held until out_ready
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             error,
   output logic             busy
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             error_q, error_d;

   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_res;
   logic             alu_err;

   always_comb begin
      in_ready  = (state_q == IDLE) && !flush;
      accept    = in_valid && in_ready;
      mul_start = accept && (alu_control == ALU_MUL);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      result    = result_q;
      zero      = zero_q;
      error     = error_q;
   end

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (alu_control)
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_MUL: alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   alu_mult_serial #(.WIDTH(WIDTH)) u_mult (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .start     (mul_start),
      .mcand_in  (op_a),
      .mplier_in (op_b),
      .done      (mul_done),
      .product   (mul_product)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      error_d  = error_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (alu_control == ALU_MUL) begin
                  state_d = MUL;
               end else begin
                  state_d  = DONE;
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  error_d  = alu_err;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               state_d  = DONE;
               result_d = mul_product;
               zero_d   = (mul_product == '0);
               error_d  = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // flush wins over any completion or handshake; held values are left as-is
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
         zero_d   = zero_q;
         error_d  = error_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         error_q  <= error_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, random ops against a
// reference model, and hand sequences for backpressure, flush and reset.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   alu_control = 4'd0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         zero;
   logic         error;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .error       (error),
      .busy        (busy)
   );

   typedef struct {
      logic [3:0]   code;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
      logic         e;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         e;
   } exp_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   r;
      longint unsigned p;
      r.e = 1'b0;
      case (code)
         4'b0000: r.res = a & b;
         4'b0001: r.res = a | b;
         4'b0010: r.res = a + b;
         4'b0110: r.res = a - b;
         4'b0111: r.res = (int'(a) < int'(b)) ? 1 : 0;
         4'b1000: begin
            p = longint'(a) * longint'(b);
            r.res = p[W-1:0];
         end
         default: begin
            r.res = '0;
            r.e   = 1'b1;
         end
      endcase
      r.z = (r.res == 0);
      return r;
   endfunction

   // Offers one op, measures edges to out_valid, checks outputs, then handshakes.
   task automatic do_op(input string name, input logic [3:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                        input logic ee);
      int   lat;
      int   exp_lat;
      logic busy_ok;
      exp_lat = (code == 4'b1000) ? W + 1 : 1;
      busy_ok = 1'b1;
      lat     = 0;
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = code;
      op_a        = a;
      op_b        = b;
      out_ready   = 1'b0;
      #1 chk({name, "_in_ready"}, W'(in_ready), W'(1));
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) break;
         if (!busy || in_ready) busy_ok = 1'b0;
      end
      chk({name, "_latency"}, W'(lat), W'(exp_lat));
      chk({name, "_busy_while_running"}, W'(busy_ok), W'(1));
      chk({name, "_result"}, result, er);
      chk({name, "_zero_err"}, W'({zero, error}), W'({ez, ee}));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_after_hs"}, W'({out_valid, in_ready}), W'(2'b01));
   endtask

   vec_t vecs[$];

   initial begin
      exp_t   m;
      logic [3:0]   rc;
      logic [W-1:0] ra, rb, held;
      logic   stable_ok;
      logic   never_valid;
      logic [3:0] codes [7];
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0000};

      vecs.push_back('{4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0});
      vecs.push_back('{4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0});
      vecs.push_back('{4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0});
      vecs.push_back('{4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0});
      vecs.push_back('{4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0});
      vecs.push_back('{4'b1000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 1'b0});
      vecs.push_back('{4'b1000, 32'h8000_0000, 32'd2, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{4'b1111, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1});
      vecs.push_back('{4'b0011, 32'd9, 32'd4, 32'd0, 1'b1, 1'b1});
      vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{4'b1000, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0});

      // reset values
      #12;
      chk("reset_outputs", W'({out_valid, busy, zero, error}), W'(0));
      chk("reset_result", result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("reset_in_ready", W'(in_ready), W'(1));

      foreach (vecs[i])
         do_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].z, vecs[i].e);

      for (int i = 0; i < 40; i++) begin
         rc = (i % 8 == 7) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 6)];
         ra = $urandom;
         rb = (i % 3 == 0) ? W'($urandom_range(0, 3)) : $urandom;
         m  = model(rc, ra, rb);
         do_op($sformatf("rnd%0d_c%0h", i, rc), rc, ra, rb, m.res, m.z, m.e);
      end

      // backpressure: result held, second op blocked until the handshake
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'b0010; op_a = 32'd100; op_b = 32'd23;
      @(negedge clk);
      op_a = 32'd40; op_b = 32'd2;
      held = result;
      chk("bp_first_result", held, 32'd123);
      stable_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!out_valid || in_ready || result !== held) stable_ok = 1'b0;
      end
      chk("bp_stable", W'(stable_ok), W'(1));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_after_hs", W'({out_valid, in_ready}), W'(2'b01));
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_second_valid", W'(out_valid), W'(1));
      chk("bp_second_result", result, 32'd42);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // flush at edge 10 of a MUL
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'b1000; op_a = 32'd7; op_b = 32'd9;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      flush = 1'b1;
      #1 chk("flush_blocks_in_ready", W'(in_ready), W'(0));
      @(negedge clk);
      flush = 1'b0;
      #1 chk("flush_idle", W'({busy, out_valid, in_ready}), W'(3'b001));
      never_valid = 1'b1;
      for (int i = 0; i < W + 5; i++) begin
         @(negedge clk);
         if (out_valid) never_valid = 1'b0;
      end
      chk("flush_no_output", W'(never_valid), W'(1));

      // flush while a result is held drops it
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'b0001; op_a = 32'd1; op_b = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1 chk("flush_done_drop", W'({out_valid, busy, in_ready}), W'(3'b001));

      // async reset mid-MUL
      do_op("pre_rst", 4'b0010, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'b1000; op_a = 32'd3; op_b = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_outputs", W'({out_valid, busy, zero, error}), W'(0));
      chk("rst_mid_result", result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_mid_in_ready", W'(in_ready), W'(1));
      never_valid = 1'b1;
      for (int i = 0; i < W + 5; i++) begin
         @(negedge clk);
         if (out_valid) never_valid = 1'b0;
      end
      chk("rst_no_output", W'(never_valid), W'(1));
      do_op("post_rst", 4'b1000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
